uart_tx_scheduler: RTL and testbench
====================================

# uart_tx_scheduler

Shares one UART transmitter among NUM_REQ byte requesters. Each requester supplies a byte and its own frame format. The block arbitrates round-robin, loads the winner's byte and format onto the UART control signals, pulses start_tx, and waits for tx_done. It also honours cts_n flow control, enforces an inter-frame gap, and recovers from a missing tx_done with a watchdog. It sits between the requesting client logic and the UART control signals in the interface bundle.

## Interface
- NUM_REQ, 4: number of requesters, 2..8.
- GAP_CYCLES, 2: idle cycles after each frame before the next grant; 0 is legal.
- TIMEOUT_CYCLES, 200000: cycles in WAIT without tx_done before abort; must be ≥1.
- clk  in  1  single clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req_valid  in  NUM_REQ  per-requester byte valid.
- req_data  in  8*NUM_REQ  bytes; requester i owns bits [8i+7:8i].
- req_cfg  in  5*NUM_REQ  frame format; requester i owns bits [5i+4:5i] = {data_bit_num[1:0], stop_bit_num, parity_en, parity_type}.
- req_ready  out  NUM_REQ  one-hot accept strobe.
- cts_n  in  1  peer clear-to-send, active-low.
- tx_done  in  1  one-cycle pulse from the UART at frame end.
- tx_data  out  8  byte to the UART.
- data_bit_num  out  2  data bits: 00=5, 01=6, 10=7, 11=8.
- stop_bit_num  out  1  0=1 stop bit, 1=2 stop bits.
- parity_en  out  1  parity enable.
- parity_type  out  1  0=even, 1=odd.
- start_tx  out  1  one-cycle frame start pulse.
- busy  out  1  high in any state except IDLE.
- grant_id  out  $clog2(NUM_REQ)  index of the last granted requester.
- timeout_err  out  1  one-cycle pulse on watchdog abort.

## Operation
- States: IDLE, START, WAIT, GAP.
- IDLE:
  - Grant when cts_n==0 and req_valid!=0.
  - Winner is the first set bit at or after rr_ptr, wrapping.
  - req_ready[winner]=1 combinationally in that cycle; that cycle is the transfer.
  - On the same edge: latch the winner's data and cfg into the output registers; set grant_id=winner and rr_ptr=(winner+1) mod NUM_REQ; go to START.
- START: start_tx=1 for exactly one cycle; clear the watchdog counter; go to WAIT.
- WAIT:
  - tx_done=1 → GAP (IDLE if GAP_CYCLES==0).
  - Otherwise, watchdog reaching TIMEOUT_CYCLES-1 → timeout_err=1 for one cycle, then same transition as tx_done.
- GAP: count GAP_CYCLES cycles, then IDLE.
- tx_done outside WAIT is ignored.
- cts_n is sampled only in IDLE. Deassertion during START/WAIT/GAP does not abort the frame.
- Requesters hold req_data/req_cfg stable while req_valid is high and until req_ready. Dropping req_valid before grant is permitted and withdraws the request.
- tx_data and format outputs hold their value from the grant until the next grant.
- Reset (any state, including mid-frame):
  - State IDLE, rr_ptr=0, grant_id=0.
  - tx_data=0, data_bit_num=2'b11, stop_bit_num=0, parity_en=0, parity_type=0.
  - start_tx=0, req_ready=0, busy=0, timeout_err=0.

## Timing
- Grant to start: req_ready in cycle T, start_tx in T+1, outputs valid from T+1.
- Frame turnaround: tx_done in cycle D → next req_ready no earlier than D+1+GAP_CYCLES.
- Throughput: at most one grant per 3+GAP_CYCLES cycles, plus frame duration.
- No combinational path from tx_done to any output.
- req_ready depends combinationally on state, cts_n, req_valid and rr_ptr only.

## Structure
- Package uart_ctrl_pkg holds:
  - state enum sched_state_t.
  - uart_cfg_t packed struct {data_bit_num, stop_bit_num, parity_en, parity_type}.
  - constant UART_CFG_W=5 and the data_bit_num encoding constants.
- Sub-module rr_arbiter (NUM_REQ): inputs req vector and rr_ptr; outputs one-hot gnt and binary gnt_idx; purely combinational.
- The scheduler holds the FSM, rr_ptr, output registers, gap counter and watchdog counter.

## Test plan
- Single request: req_valid=4'b0010, data 8'hA5, cfg 5'b11011 → req_ready=4'b0010 for 1 cycle. Next cycle: start_tx=1, tx_data=A5, data_bit_num=11, stop_bit_num=0, parity_en=1, parity_type=1.
- Fairness: all four valid continuously, tx_done 10 cycles after each start_tx → grant order 0,1,2,3,0; consecutive grants spaced by GAP_CYCLES.
- Flow control: cts_n=1 with req_valid=4'b0001 → no req_ready for 50 cycles. cts_n→0 → grant next cycle. cts_n→1 during WAIT → frame still completes.
- Watchdog: TIMEOUT_CYCLES=16, no tx_done → timeout_err pulse 16 cycles after start_tx; returns to IDLE after the gap; next request is served.
- Reset mid-frame: reset_n low in WAIT → all outputs at reset values. After release, request 3 is granted before request 0 only if rr_ptr rules allow; expected order starts at 0.
- Stray tx_done in IDLE/GAP → no state change; GAP_CYCLES=0 → back-to-back grants spaced 3 cycles.

Source files
------------

// File: rtl/uart_tx_scheduler_pkg.sv
// Shared types and constants for the UART transmit scheduler.
package uart_ctrl_pkg;

  localparam int UART_CFG_W = 5;

  localparam logic [1:0] DBN_5 = 2'b00;
  localparam logic [1:0] DBN_6 = 2'b01;
  localparam logic [1:0] DBN_7 = 2'b10;
  localparam logic [1:0] DBN_8 = 2'b11;

  typedef enum logic [1:0] {IDLE, START, WAIT, GAP} sched_state_t;

  typedef struct packed {
    logic [1:0] data_bit_num;
    logic       stop_bit_num;
    logic       parity_en;
    logic       parity_type;
  } uart_cfg_t;

  localparam uart_cfg_t CFG_RESET = '{data_bit_num: DBN_8, stop_bit_num: 1'b0,
                                      parity_en: 1'b0, parity_type: 1'b0};

  // Number of data bits carried by a frame with the given encoding.
  function automatic int data_bits(input logic [1:0] dbn);
    case (dbn)
      DBN_5:   return 5;
      DBN_6:   return 6;
      DBN_7:   return 7;
      default: return 8;
    endcase
  endfunction

endpackage

// File: rtl/uart_tx_scheduler_if.sv
// Requester handshake plus UART control bundle; master = scheduler, slave = clients/UART.
interface uart_tx_scheduler_if #(parameter int NUM_REQ = 4);
  import uart_ctrl_pkg::*;

  localparam int IDX_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]            req_valid;
  logic [8*NUM_REQ-1:0]          req_data;
  logic [UART_CFG_W*NUM_REQ-1:0] req_cfg;
  logic [NUM_REQ-1:0]            req_ready;
  logic                          cts_n;
  logic                          tx_done;
  logic [7:0]                    tx_data;
  logic [1:0]                    data_bit_num;
  logic                          stop_bit_num;
  logic                          parity_en;
  logic                          parity_type;
  logic                          start_tx;
  logic                          busy;
  logic [IDX_W-1:0]              grant_id;
  logic                          timeout_err;

  modport master (
    input  req_valid, req_data, req_cfg, cts_n, tx_done,
    output req_ready, tx_data, data_bit_num, stop_bit_num, parity_en, parity_type,
           start_tx, busy, grant_id, timeout_err
  );

  modport slave (
    output req_valid, req_data, req_cfg, cts_n, tx_done,
    input  req_ready, tx_data, data_bit_num, stop_bit_num, parity_en, parity_type,
           start_tx, busy, grant_id, timeout_err
  );

endinterface

// File: rtl/uart_tx_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first set request at or after rr_ptr, wrapping.
module rr_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] rr_ptr,
  output logic [NUM_REQ-1:0]         gnt,
  output logic [$clog2(NUM_REQ)-1:0] gnt_idx
);

  localparam int IDX_W = $clog2(NUM_REQ);

  logic found;
  int   idx;

  // NOTE: every output gets a default before the loop so no latch is inferred.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(rr_ptr) + k) % NUM_REQ;
      if (!found && req[IDX_W'(idx)]) begin
        found               = 1'b1;
        gnt[IDX_W'(idx)]    = 1'b1;
        gnt_idx             = IDX_W'(idx);
      end
    end
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler sharing one UART transmitter among NUM_REQ byte requesters.
module uart_tx_scheduler
  import uart_ctrl_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int GAP_CYCLES     = 2,
  parameter int TIMEOUT_CYCLES = 200000
) (
  input  logic                  clk,
  input  logic                  reset_n,
  uart_tx_scheduler_if.master   bus
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int WD_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT_CYCLES - 1);

  sched_state_t     state, state_nxt;
  logic [IDX_W-1:0] rr_ptr, grant_id, gnt_idx;
  logic [NUM_REQ-1:0] gnt;
  logic [GAP_W-1:0] gap_cnt;
  logic [WD_W-1:0]  wd_cnt;
  logic [7:0]       tx_data;
  uart_cfg_t        cfg;
  logic             grant, wd_expired;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req     (bus.req_valid),
    .rr_ptr  (rr_ptr),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  assign grant      = (state == IDLE) && !bus.cts_n && (|bus.req_valid);
  assign wd_expired = (wd_cnt == WD_LAST);

  always_comb begin
    state_nxt       = state;
    bus.req_ready   = '0;
    bus.start_tx    = 1'b0;
    bus.timeout_err = 1'b0;
    bus.busy        = (state != IDLE);
    unique case (state)
      IDLE: begin
        if (!bus.cts_n) begin
          bus.req_ready = gnt;
          if (|bus.req_valid) state_nxt = START;
        end
      end
      START: begin
        bus.start_tx = 1'b1;
        state_nxt    = WAIT;
      end
      WAIT: begin
        // Timeout is decided from the counter alone, keeping tx_done off every output path.
        bus.timeout_err = wd_expired;
        if (bus.tx_done || wd_expired) state_nxt = (GAP_CYCLES == 0) ? IDLE : GAP;
      end
      GAP: begin
        if (gap_cnt == GAP_LAST) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr   <= '0;
      grant_id <= '0;
      tx_data  <= '0;
      cfg      <= CFG_RESET;
      gap_cnt  <= '0;
      wd_cnt   <= '0;
    end else begin
      if (grant) begin
        tx_data  <= bus.req_data[8*int'(gnt_idx) +: 8];
        cfg      <= bus.req_cfg[UART_CFG_W*int'(gnt_idx) +: UART_CFG_W];
        grant_id <= gnt_idx;
        rr_ptr   <= (gnt_idx == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
      end
      if (state == START)     wd_cnt <= '0;
      else if (state == WAIT) wd_cnt <= wd_cnt + 1'b1;
      if (state == GAP) gap_cnt <= gap_cnt + 1'b1;
      else              gap_cnt <= '0;
    end
  end

  assign bus.tx_data      = tx_data;
  assign bus.data_bit_num = cfg.data_bit_num;
  assign bus.stop_bit_num = cfg.stop_bit_num;
  assign bus.parity_en    = cfg.parity_en;
  assign bus.parity_type  = cfg.parity_type;
  assign bus.grant_id     = grant_id;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Self-checking bench: vector table, directed corner sequences, randomized run vs timeline model.
module tb_uart_tx_scheduler;

  localparam int N   = 4;
  localparam int GAP = 2;
  localparam int TMO = 16;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  uart_tx_scheduler_if #(.NUM_REQ(N)) ifa ();
  uart_tx_scheduler_if #(.NUM_REQ(N)) ifb ();

  uart_tx_scheduler #(.NUM_REQ(N), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset_n(reset_n), .bus(ifa)
  );
  uart_tx_scheduler #(.NUM_REQ(N), .GAP_CYCLES(0), .TIMEOUT_CYCLES(TMO)) dut_gap0 (
    .clk(clk), .reset_n(reset_n), .bus(ifb)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic sample_edge();
    @(negedge clk);
  endtask

  function automatic logic [4:0] out_cfg();
    return {ifa.data_bit_num, ifa.stop_bit_num, ifa.parity_en, ifa.parity_type};
  endfunction

  task automatic idle_inputs();
    ifa.req_valid = '0; ifa.req_data = '0; ifa.req_cfg = '0; ifa.cts_n = 1'b0; ifa.tx_done = 1'b0;
    ifb.req_valid = '0; ifb.req_data = '0; ifb.req_cfg = '0; ifb.cts_n = 1'b0; ifb.tx_done = 1'b0;
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_ready"},   ifa.req_ready, 0);
    check({tag, "_tx_data"}, ifa.tx_data, 0);
    check({tag, "_cfg"},     out_cfg(), 5'b11000);
    check({tag, "_start"},   ifa.start_tx, 0);
    check({tag, "_busy"},    ifa.busy, 0);
    check({tag, "_timeout"}, ifa.timeout_err, 0);
    check({tag, "_grant_id"}, ifa.grant_id, 0);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    idle_inputs();
    @(negedge clk);
    @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  typedef struct {
    logic        cts_n;
    logic [3:0]  valid;
    logic [31:0] data;
    logic [19:0] cfg;
    logic [3:0]  exp_ready;
    logic [7:0]  exp_tx;
    logic [4:0]  exp_cfg;
    int          exp_id;
  } vec_t;

  vec_t tbl[9];

  int gid[$];
  int gcyc[$];
  int bg[$];
  int start_c, last_g, seen, first_to, to_count, last_busy;

  // Randomized-run model state: a frame timeline plus round-robin pointer.
  logic [7:0] rd[N];
  logic [4:0] rc[N];
  logic [N-1:0] rv;
  int free_at, start_at, end_at, done_at, to_at, ptr, win, d;
  logic [7:0] m_tx;
  logic [4:0] m_cfg;
  int m_id;
  logic [3:0] exp_ready;
  logic stray;

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{1'b0, 4'b0010, 32'h0000_A500, {5'b00000, 5'b00000, 5'b11011, 5'b00000}, 4'b0010, 8'hA5, 5'b11011, 1};
    tbl[1] = '{1'b0, 4'b0011, 32'h4433_2211, {5'b00001, 5'b00010, 5'b00100, 5'b01000}, 4'b0001, 8'h11, 5'b01000, 0};
    tbl[2] = '{1'b0, 4'b1010, 32'h4433_2211, {5'b00001, 5'b00010, 5'b00100, 5'b01000}, 4'b0010, 8'h22, 5'b00100, 1};
    tbl[3] = '{1'b0, 4'b1001, 32'h4433_2211, {5'b00001, 5'b00010, 5'b00100, 5'b01000}, 4'b1000, 8'h44, 5'b00001, 3};
    tbl[4] = '{1'b0, 4'b1111, 32'h4433_2211, {5'b00001, 5'b00010, 5'b00100, 5'b01000}, 4'b0001, 8'h11, 5'b01000, 0};
    tbl[5] = '{1'b0, 4'b0000, 32'h4433_2211, {5'b00001, 5'b00010, 5'b00100, 5'b01000}, 4'b0000, 8'h11, 5'b01000, 0};
    tbl[6] = '{1'b1, 4'b1111, 32'h4433_2211, {5'b00001, 5'b00010, 5'b00100, 5'b01000}, 4'b0000, 8'h11, 5'b01000, 0};
    tbl[7] = '{1'b0, 4'b0101, 32'h4433_2211, {5'b00001, 5'b00010, 5'b00100, 5'b01000}, 4'b0100, 8'h33, 5'b00010, 2};
    tbl[8] = '{1'b0, 4'b1000, 32'hC300_0000, {5'b10110, 5'b00000, 5'b00000, 5'b00000}, 4'b1000, 8'hC3, 5'b10110, 3};

    reset_n = 1'b0;
    idle_inputs();
    @(negedge clk);
    check_reset("por");
    @(posedge clk);
    #1 reset_n = 1'b1;

    // Table: one transfer per row, rr_ptr carried from row to row.
    for (int i = 0; i < 9; i++) begin
      drive_edge();
      ifa.cts_n = tbl[i].cts_n; ifa.req_valid = tbl[i].valid;
      ifa.req_data = tbl[i].data; ifa.req_cfg = tbl[i].cfg;
      sample_edge();
      check($sformatf("tbl%0d_ready", i), ifa.req_ready, tbl[i].exp_ready);
      drive_edge();
      ifa.req_valid = '0; ifa.cts_n = 1'b0;
      sample_edge();
      check($sformatf("tbl%0d_start", i), ifa.start_tx, (tbl[i].exp_ready != 0));
      check($sformatf("tbl%0d_busy", i), ifa.busy, (tbl[i].exp_ready != 0));
      check($sformatf("tbl%0d_tx_data", i), ifa.tx_data, tbl[i].exp_tx);
      check($sformatf("tbl%0d_cfg", i), out_cfg(), tbl[i].exp_cfg);
      check($sformatf("tbl%0d_grant_id", i), ifa.grant_id, tbl[i].exp_id);
      if (tbl[i].exp_ready != 0) begin
        drive_edge(); ifa.tx_done = 1'b1;
        drive_edge(); ifa.tx_done = 1'b0;
        repeat (GAP - 1) drive_edge();
      end
    end

    // Fairness: all valid, tx_done 10 cycles after each start_tx.
    do_reset();
    ifa.req_data = 32'h4433_2211;
    start_c = -100;
    for (int c = 0; c < 120 && gid.size() < 5; c++) begin
      drive_edge();
      ifa.req_valid = 4'hF;
      ifa.tx_done = (c == start_c + 10);
      sample_edge();
      if (ifa.req_ready != 0) begin
        check("fair_onehot", $onehot(ifa.req_ready), 1);
        gid.push_back($clog2(ifa.req_ready));
        gcyc.push_back(c);
        start_c = c + 1;
      end
    end
    check("fair_count", gid.size(), 5);
    for (int k = 0; k < gid.size(); k++) check($sformatf("fair_order%0d", k), gid[k], k % N);
    for (int k = 1; k < gcyc.size(); k++)
      check($sformatf("fair_spacing%0d", k), gcyc[k] - gcyc[k-1], 1 + 10 + 1 + GAP);

    // Flow control: cts_n blocks grants only while idle.
    do_reset();
    ifa.cts_n = 1'b1; ifa.req_valid = 4'b0001; ifa.req_data = 32'h0000_005A;
    seen = 0;
    for (int c = 0; c < 50; c++) begin
      drive_edge();
      sample_edge();
      if (ifa.req_ready != 0) seen++;
    end
    check("cts_blocked", seen, 0);
    drive_edge(); ifa.cts_n = 1'b0;
    sample_edge(); check("cts_grant", ifa.req_ready, 4'b0001);
    drive_edge(); ifa.req_valid = '0; ifa.cts_n = 1'b1;
    sample_edge(); check("cts_start", ifa.start_tx, 1);
    repeat (4) drive_edge();
    drive_edge(); ifa.tx_done = 1'b1;
    sample_edge(); check("cts_wait_busy", ifa.busy, 1);
    drive_edge(); ifa.tx_done = 1'b0;
    repeat (GAP - 1) drive_edge();
    sample_edge(); check("cts_gap_busy", ifa.busy, 1);
    drive_edge();
    sample_edge(); check("cts_idle", ifa.busy, 0);
    check("cts_no_timeout", ifa.timeout_err, 0);

    // Watchdog: no tx_done at all.
    do_reset();
    drive_edge(); ifa.req_valid = 4'b0100; ifa.req_data = 32'h0077_0000;
    sample_edge(); check("wd_grant", ifa.req_ready, 4'b0100);
    drive_edge(); ifa.req_valid = '0;
    sample_edge(); check("wd_start", ifa.start_tx, 1);
    first_to = -1; to_count = 0; last_busy = -1;
    for (int k = 1; k <= 40; k++) begin
      drive_edge();
      sample_edge();
      if (ifa.timeout_err) begin
        to_count++;
        if (first_to < 0) first_to = k;
      end
      if (ifa.busy) last_busy = k;
    end
    check("wd_latency", first_to, TMO);
    check("wd_pulses", to_count, 1);
    check("wd_last_busy", last_busy, TMO + GAP);
    drive_edge(); ifa.req_valid = 4'b0001;
    sample_edge(); check("wd_next_grant", ifa.req_ready, 4'b0001);

    // Reset in the middle of a frame.
    do_reset();
    drive_edge(); ifa.req_valid = 4'b0100; ifa.req_data = 32'h00EE_0000;
    drive_edge(); ifa.req_valid = '0;
    drive_edge();
    drive_edge(); reset_n = 1'b0;
    sample_edge(); check_reset("midrst");
    drive_edge(); reset_n = 1'b1;
    drive_edge(); ifa.req_valid = 4'b1001;
    sample_edge(); check("midrst_order", ifa.req_ready, 4'b0001);

    // Stray tx_done in IDLE and in GAP.
    do_reset();
    drive_edge(); ifa.tx_done = 1'b1;
    sample_edge(); check("stray_idle_busy", ifa.busy, 0);
    drive_edge(); ifa.tx_done = 1'b0;
    sample_edge(); check("stray_idle_start", ifa.start_tx, 0);
    drive_edge(); ifa.req_valid = 4'b0001;
    drive_edge(); ifa.req_valid = '0;
    drive_edge(); ifa.tx_done = 1'b1;
    drive_edge();
    sample_edge(); check("stray_gap_busy", ifa.busy, 1);
    drive_edge(); ifa.tx_done = 1'b0;
    sample_edge(); check("stray_gap_busy2", ifa.busy, 1);
    drive_edge(); ifa.req_valid = 4'b0010;
    sample_edge(); check("stray_gap_ready", ifa.req_ready, 4'b0010);
    drive_edge(); ifa.req_valid = '0;
    sample_edge(); check("stray_gap_start", ifa.start_tx, 1);

    // GAP_CYCLES = 0: back-to-back grants three cycles apart.
    do_reset();
    ifb.req_data = 32'h0000_0033;
    last_g = -100;
    for (int c = 0; c < 30 && bg.size() < 4; c++) begin
      drive_edge();
      ifb.req_valid = 4'b0001;
      ifb.tx_done = (c == last_g + 2);
      sample_edge();
      if (ifb.req_ready != 0) begin
        bg.push_back(c);
        last_g = c;
      end
    end
    check("gap0_count", bg.size(), 4);
    for (int k = 1; k < bg.size(); k++) check($sformatf("gap0_spacing%0d", k), bg[k] - bg[k-1], 3);

    // Randomized run against a frame-timeline model.
    do_reset();
    rv = '0; free_at = 0; start_at = -1000; end_at = -1000; done_at = -1000; to_at = -1000;
    ptr = 0; m_tx = 8'h00; m_cfg = 5'b11000; m_id = 0;
    for (int i = 0; i < N; i++) begin rd[i] = '0; rc[i] = '0; end
    for (int c = 0; c < 3000; c++) begin
      drive_edge();
      for (int i = 0; i < N; i++) begin
        if (!rv[i]) begin
          if ($urandom_range(3) == 0) begin
            rv[i] = 1'b1; rd[i] = 8'($urandom); rc[i] = 5'($urandom);
          end
        end else if ($urandom_range(15) == 0) begin
          rv[i] = 1'b0;
        end
      end
      stray = !(c >= start_at + 1 && c <= end_at) && ($urandom_range(7) == 0);
      ifa.cts_n = ($urandom_range(3) == 0);
      ifa.tx_done = (c == done_at) || stray;
      ifa.req_valid = rv;
      for (int i = 0; i < N; i++) begin
        ifa.req_data[8*i +: 8] = rd[i];
        ifa.req_cfg[5*i +: 5]  = rc[i];
      end
      sample_edge();
      win = -1;
      if (c >= free_at && !ifa.cts_n)
        for (int k = 0; k < N; k++)
          if (win < 0 && rv[(ptr + k) % N]) win = (ptr + k) % N;
      exp_ready = (win >= 0) ? 4'(1 << win) : 4'b0000;
      check("rnd_ready",    ifa.req_ready, exp_ready);
      check("rnd_start",    ifa.start_tx, (c == start_at));
      check("rnd_busy",     ifa.busy, (c < free_at));
      check("rnd_timeout",  ifa.timeout_err, (c == to_at));
      check("rnd_tx_data",  ifa.tx_data, m_tx);
      check("rnd_cfg",      out_cfg(), m_cfg);
      check("rnd_grant_id", ifa.grant_id, m_id);
      if (win >= 0) begin
        m_tx = rd[win]; m_cfg = rc[win]; m_id = win;
        ptr = (win + 1) % N;
        start_at = c + 1;
        d = $urandom_range(20, 1);
        if (d < TMO) begin
          done_at = start_at + d; to_at = -1000; end_at = done_at;
        end else begin
          done_at = -1000; to_at = start_at + TMO; end_at = to_at;
        end
        free_at = end_at + 1 + GAP;
        rv[win] = 1'b0;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
